// File: rtl/phys_pkg.sv
// Shared types and constants for the per-frame physics sequencer.
// Pair table lists the 4-dog pairs in lexicographic order; smaller N uses the entries with b < N.
package phys_pkg;

  localparam int MAX_DOGS  = 4;
  localparam int MAX_PAIRS = 6;
  localparam int PAIR_W    = 3;

  typedef enum logic [1:0] {IDLE, UPD, COL, DONE} state_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } pair_t;

  localparam pair_t PAIR_LUT [MAX_PAIRS] = '{
    '{2'd0, 2'd1}, '{2'd0, 2'd2}, '{2'd0, 2'd3},
    '{2'd1, 2'd2}, '{2'd1, 2'd3}, '{2'd2, 2'd3}
  };

  // p-th pair among those whose dogs both exist for an n-dog configuration
  function automatic pair_t pair_of(input int n, input logic [PAIR_W-1:0] p);
    int    k;
    pair_t r;
    k = 0;
    r = '0;
    for (int i = 0; i < MAX_PAIRS; i++) begin
      if (int'(PAIR_LUT[i].b) < n) begin
        if (k == int'(p)) r = PAIR_LUT[i];
        k = k + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_cooldown.sv
// Per-pair collision cooldown counters: load on applied hit, all decrement once per frame start.
// Zero flag for the selected pair is combinational; load takes effect at the next edge.
module pair_cooldown import phys_pkg::*; #(
  parameter int CD_FRAMES = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PAIR_W-1:0] pair,
  input  logic              load,
  input  logic              dec_all,
  output logic              zero
);

  logic [3:0] cnt [MAX_PAIRS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_PAIRS; i++) cnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < MAX_PAIRS; i++) begin
        if (load && pair == PAIR_W'(i))
          cnt[i] <= 4'(CD_FRAMES);
        else if (dec_all && cnt[i] != 4'd0)
          cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

  always_comb begin
    zero = 1'b1;
    for (int i = 0; i < MAX_PAIRS; i++)
      if (pair == PAIR_W'(i)) zero = (cnt[i] == 4'd0);
  end

endmodule

// File: rtl/phys_scheduler.sv
// Frame sequencer: N updates then P pair checks over req/ack, one transaction per ack (1 cycle min).
// Stalls on missing ack up to TIMEOUT cycles, then skips; ticks while busy queue one deep.
module phys_scheduler import phys_pkg::*; #(
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int CD_FRAMES = 5,
  parameter int TIMEOUT   = 63
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             enable,
  output logic             upd_req,
  output logic [IDX_W-1:0] upd_idx,
  input  logic             upd_ack,
  output logic             col_req,
  output logic [IDX_W-1:0] col_idx_a,
  output logic [IDX_W-1:0] col_idx_b,
  input  logic             col_ack,
  input  logic             col_hit,
  output logic             col_apply,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output logic             ack_err
);

  localparam int P = N * (N - 1) / 2;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [PAIR_W-1:0] pair;
  logic [7:0]        tcnt;
  logic              pending;
  logic              start, waiting, tmo, upd_adv, col_adv, last_idx, last_pair;
  logic              cd_zero, tick_busy;
  pair_t             cur_pair;

  assign cur_pair   = pair_of(N, pair);
  assign upd_req    = (state == UPD);
  assign col_req    = (state == COL);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);
  assign upd_idx    = idx;
  assign col_idx_a  = IDX_W'(cur_pair.a);
  assign col_idx_b  = IDX_W'(cur_pair.b);

  assign start     = (state == IDLE) && enable && (frame_tick || pending);
  assign tick_busy = busy && frame_tick && enable;
  assign waiting   = (upd_req && !upd_ack) || (col_req && !col_ack);
  // expiry fires on the TIMEOUT-th consecutive waiting cycle of a request
  assign tmo       = waiting && (tcnt == 8'(TIMEOUT - 1));
  assign upd_adv   = upd_req && (upd_ack || tmo);
  assign col_adv   = col_req && (col_ack || tmo);
  assign last_idx  = (idx == IDX_W'(N - 1));
  assign last_pair = (pair == PAIR_W'(P - 1));
  assign col_apply = col_req && col_ack && col_hit && cd_zero;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UPD;
      UPD:     if (upd_adv && last_idx) state_nxt = COL;
      COL:     if (col_adv && last_pair) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      pair    <= '0;
      tcnt    <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      if (start)
        idx <= '0;
      else if (upd_adv && !last_idx)
        idx <= idx + IDX_W'(1);

      if (upd_adv)
        pair <= '0;
      else if (col_adv && !last_pair)
        pair <= pair + PAIR_W'(1);

      if (upd_adv || col_adv) tcnt <= '0;
      else if (waiting)       tcnt <= tcnt + 8'd1;
      else                    tcnt <= '0;

      if (tick_busy)  pending <= 1'b1;
      else if (start) pending <= 1'b0;

      if (tick_busy) overrun <= 1'b1;
      if (tmo)       ack_err <= 1'b1;
    end
  end

  pair_cooldown #(.CD_FRAMES(CD_FRAMES)) u_cooldown (
    .clk     (clk),
    .rst_n   (rst_n),
    .pair    (pair),
    .load    (col_apply),
    .dec_all (start),
    .zero    (cd_zero)
  );

endmodule

// File: tb/tb_phys_scheduler.sv
// Bench for phys_scheduler: frame-level reference model checked every cycle plus directed timing checks.
module tb_phys_scheduler;

  localparam int N   = 4;
  localparam int IDX_W = 2;
  localparam int CD  = 5;
  localparam int TMO = 63;
  localparam int P   = 6;

  logic clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, enable = 1'b0;
  logic upd_ack = 1'b0, col_ack = 1'b0, col_hit = 1'b0;
  logic upd_req, col_req, col_apply, frame_done, busy, overrun, ack_err;
  logic [IDX_W-1:0] upd_idx, col_idx_a, col_idx_b;

  phys_scheduler #(.N(N), .IDX_W(IDX_W), .CD_FRAMES(CD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable),
    .upd_req(upd_req), .upd_idx(upd_idx), .upd_ack(upd_ack),
    .col_req(col_req), .col_idx_a(col_idx_a), .col_idx_b(col_idx_b),
    .col_ack(col_ack), .col_hit(col_hit), .col_apply(col_apply),
    .frame_done(frame_done), .busy(busy), .overrun(overrun), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
  endtask

  // Reference model: a frame is a list of N updates then P pair checks, then a done step.
  int m_step = -1, m_wait = 0;
  bit m_pend = 0, m_ovr = 0, m_err = 0;
  int m_cd [P];
  int pa [P], pb [P];

  initial begin
    int k;
    k = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++) begin
        pa[k] = a; pb[k] = b; k++;
      end
    for (int i = 0; i < P; i++) m_cd[i] = 0;
  end

  always @(negedge clk) begin : cmp_blk
    int eu, ec, ed, eap, cpi, ack;
    if (!rst_n) begin
      m_step = -1; m_wait = 0; m_pend = 0; m_ovr = 0; m_err = 0;
      for (int i = 0; i < P; i++) m_cd[i] = 0;
    end
    eu  = (m_step >= 0 && m_step < N);
    ec  = (m_step >= N && m_step < N + P);
    ed  = (m_step == N + P);
    cpi = ec ? m_step - N : 0;
    eap = (ec && col_ack && col_hit && m_cd[cpi] == 0);
    chk("upd_req", upd_req, eu);
    if (eu) chk("upd_idx", upd_idx, m_step);
    chk("col_req", col_req, ec);
    if (ec) begin
      chk("col_idx_a", col_idx_a, pa[cpi]);
      chk("col_idx_b", col_idx_b, pb[cpi]);
    end
    chk("frame_done", frame_done, ed);
    chk("busy", busy, m_step >= 0);
    chk("col_apply", col_apply, eap);
    chk("overrun", overrun, m_ovr);
    chk("ack_err", ack_err, m_err);
    if (rst_n) begin
      if (m_step < 0) begin
        if (enable && (frame_tick || m_pend)) begin
          m_step = 0; m_wait = 0; m_pend = 0;
          for (int i = 0; i < P; i++) if (m_cd[i] > 0) m_cd[i]--;
        end
      end else begin
        if (frame_tick && enable) begin m_pend = 1; m_ovr = 1; end
        if (ed) m_step = -1;
        else begin
          ack = eu ? upd_ack : col_ack;
          if (eap) m_cd[cpi] = CD;
          if (ack) begin m_step++; m_wait = 0; end
          else if (m_wait + 1 == TMO) begin m_step++; m_wait = 0; m_err = 1; end
          else m_wait++;
        end
      end
    end
  end

  // Responders for the shared units.
  int upd_mode = 0, col_mode = 0, hit_mode = 0, ucnt = 0;
  always @(posedge clk) begin
    #1;
    if (upd_mode == 0) upd_ack = 1'b1;
    else if (upd_req) begin
      ucnt++;
      upd_ack = (ucnt == 4);
      if (ucnt == 4) ucnt = 0;
    end else begin
      ucnt = 0; upd_ack = 1'b0;
    end
    col_ack = (col_mode == 0) ? 1'b1 : !(col_req && col_idx_a == 2'd1 && col_idx_b == 2'd2);
    col_hit = (hit_mode == 0) ? 1'b0 :
              (hit_mode == 1) ? (col_idx_a == 2'd0 && col_idx_b == 2'd1) : 1'b1;
  end

  int app01 = 0, app12 = 0, app_other = 0, app_all = 0, req12 = 0;
  always @(negedge clk) begin
    if (col_apply) begin
      app_all++;
      if (col_idx_a == 2'd0 && col_idx_b == 2'd1) app01++;
      else app_other++;
      if (col_idx_a == 2'd1 && col_idx_b == 2'd2) app12++;
    end
    if (col_req && col_idx_a == 2'd1 && col_idx_b == 2'd2) req12++;
  end

  int t0 = 0;

  task automatic tick();
    @(posedge clk); #1;
    frame_tick = 1'b1; t0 = cyc;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin at = cyc; break; end
    end
    chk("done_seen", at >= 0, 1);
  endtask

  int ta [P], tb [P];

  initial begin
    int at, s, so, s12, sa;
    ta = '{0, 0, 0, 1, 1, 2};
    tb = '{1, 2, 3, 2, 3, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_upd_req", upd_req, 0);
    chk("rst_col_req", col_req, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ack_err", ack_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ticks with enable low are ignored
    tick();
    repeat (3) @(negedge clk);
    chk("en_low_busy", busy, 0);
    chk("en_low_overrun", overrun, 0);
    @(posedge clk); #1;
    enable = 1'b1;

    // 1: acks tied high
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      frame_tick = (k == 0);
      if (k == 0) t0 = cyc;
      @(negedge clk);
      chk($sformatf("t1_upd_req_k%0d", k), upd_req, (k >= 1 && k <= 4));
      if (k >= 1 && k <= 4) chk($sformatf("t1_upd_idx_k%0d", k), upd_idx, k - 1);
      chk($sformatf("t1_col_req_k%0d", k), col_req, (k >= 5 && k <= 10));
      if (k >= 5 && k <= 10) begin
        chk($sformatf("t1_a_k%0d", k), col_idx_a, ta[k-5]);
        chk($sformatf("t1_b_k%0d", k), col_idx_b, tb[k-5]);
      end
      chk($sformatf("t1_done_k%0d", k), frame_done, (k == 11));
      chk($sformatf("t1_busy_k%0d", k), busy, (k >= 1 && k <= 11));
    end

    // 2: update acks delayed
    upd_mode = 1;
    tick();
    wait_done(100, at);
    chk("t2_done_cycle", at - t0, 23);
    upd_mode = 0;

    // 3: hit on (0,1) every frame
    hit_mode = 1;
    so = app_other;
    for (int f = 0; f <= 10; f++) begin
      s = app01;
      tick();
      wait_done(50, at);
      chk($sformatf("t3_apply01_f%0d", f), app01 - s, (f % 5 == 0) ? 1 : 0);
    end
    chk("t3_other_pairs", app_other - so, 0);
    hit_mode = 0;

    // 4: ticks at 0, 5 (queued) and 8 (dropped)
    for (int k = 0; k <= 26; k++) begin
      @(posedge clk); #1;
      frame_tick = (k == 0 || k == 5 || k == 8);
      if (k == 0) t0 = cyc;
      @(negedge clk);
      if (k == 4)  chk("t4_overrun_pre", overrun, 0);
      if (k == 9)  chk("t4_overrun", overrun, 1);
      if (k == 11) chk("t4_done1", frame_done, 1);
      if (k == 12) chk("t4_gap_busy", busy, 0);
      if (k == 13) begin
        chk("t4_restart_req", upd_req, 1);
        chk("t4_restart_idx", upd_idx, 0);
      end
      if (k == 23) chk("t4_done2", frame_done, 1);
      if (k == 25) chk("t4_no_third", busy, 0);
    end
    @(posedge clk); #1;

    // 5: no col_ack on (1,2)
    chk("t5_err_pre", ack_err, 0);
    col_mode = 1; hit_mode = 2;
    s12 = req12; sa = app12;
    tick();
    wait_done(200, at);
    chk("t5_done_cycle", at - t0, 73);
    chk("t5_wait_cycles", req12 - s12, 63);
    chk("t5_no_apply12", app12 - sa, 0);
    chk("t5_ack_err", ack_err, 1);
    col_mode = 0;

    // 6: reset while checking pair 2
    tick();
    while (cyc < t0 + 7) begin @(posedge clk); #1; end
    chk("t6_pre_col_req", col_req, 1);
    chk("t6_pre_b", col_idx_b, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_col_req", col_req, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ack_err", ack_err, 0);
    chk("t6_rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s = app_all;
    tick();
    @(negedge clk);
    chk("t6_restart_req", upd_req, 1);
    chk("t6_restart_idx", upd_idx, 0);
    wait_done(50, at);
    chk("t6_all_pairs_apply", app_all - s, 6);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
